// File: rtl/smoldvi_pkg.sv
// smoldvi_pkg: shared link-sequencer state encodings and TMDS control symbols
package smoldvi_pkg;
  localparam int W_SYM_DEF = 10;
  localparam logic [2:0] S_OFF        = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_SETTLE_IN  = 3'd2;
  localparam logic [2:0] S_SETTLE_OUT = 3'd3;
  localparam logic [2:0] S_TRAIN      = 3'd4;
  localparam logic [2:0] S_RUN        = 3'd5;
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
endpackage

// File: rtl/smoldvi_sync2.sv
// smoldvi_sync2: two-flop synchroniser with async active-low reset to 0
module smoldvi_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/smoldvi_link_seq.sv
// smoldvi_link_seq: DVI gearbox bring-up, training and run sequencer
module smoldvi_link_seq import smoldvi_pkg::*; #(
  parameter int N_LANES = 3,
  parameter int W_SYM = W_SYM_DEF,
  parameter int SETTLE_CYCLES = 1024,
  parameter int TRAIN_SYMBOLS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       pll_locked,
  input  logic [N_LANES*W_SYM-1:0]   sym_in,
  output logic                       sym_ack,
  output logic                       gb_rst_n_in,
  output logic                       gb_rst_n_out_req,
  output logic [N_LANES*W_SYM-1:0]   lane_din,
  output logic                       link_up,
  output logic [2:0]                 state
);
  localparam int CW = $clog2(SETTLE_CYCLES > TRAIN_SYMBOLS ? SETTLE_CYCLES : TRAIN_SYMBOLS) + 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TRN_LAST = CW'(TRAIN_SYMBOLS - 1);
  localparam logic [N_LANES*W_SYM-1:0] IDLE = {N_LANES{W_SYM'(CTRL_00)}};
  logic lock_s, counting;
  logic [2:0] nxt;
  logic [CW-1:0] cnt;
  smoldvi_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(lock_s));
  assign counting = state == S_SETTLE_IN || state == S_SETTLE_OUT || state == S_TRAIN;
  // next state: teardown (enable before lock) overrides any terminal count
  always_comb begin
    nxt = S_OFF;
    if (state == S_OFF) nxt = enable ? S_WAIT_LOCK : S_OFF;
    else if (state > S_RUN || !enable) nxt = S_OFF;
    else if (!lock_s) nxt = S_WAIT_LOCK;
    else
      case (state)
        S_WAIT_LOCK:  nxt = S_SETTLE_IN;
        S_SETTLE_IN:  nxt = cnt == SET_LAST ? S_SETTLE_OUT : S_SETTLE_IN;
        S_SETTLE_OUT: nxt = cnt == SET_LAST ? S_TRAIN : S_SETTLE_OUT;
        S_TRAIN:      nxt = cnt == TRN_LAST ? S_RUN : S_TRAIN;
        default:      nxt = S_RUN;
      endcase
  end
  // outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= S_OFF;
      cnt              <= '0;
      gb_rst_n_in      <= 1'b0;
      gb_rst_n_out_req <= 1'b0;
      link_up          <= 1'b0;
      sym_ack          <= 1'b0;
      lane_din         <= IDLE;
    end else begin
      state            <= nxt;
      cnt              <= nxt != state ? '0 : counting ? cnt + 1'b1 : cnt;
      gb_rst_n_in      <= nxt >= S_SETTLE_IN;
      gb_rst_n_out_req <= nxt >= S_SETTLE_OUT;
      link_up          <= nxt == S_RUN;
      sym_ack          <= nxt == S_RUN;
      lane_din         <= nxt == S_RUN ? sym_in : IDLE;
    end
endmodule

// File: tb/tb_smoldvi_link_seq.sv
// tb_smoldvi_link_seq: directed checks of bring-up, run, teardown and reset
module tb_smoldvi_link_seq;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [29:0] IDLE = {C00, C00, C00};
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pll_locked = 1'b0;
  logic [29:0] sym_in = '0, lane_din;
  logic sym_ack, gb_rst_n_in, gb_rst_n_out_req, link_up;
  logic [2:0] state;
  int cyc = 0, n_chk = 0, n_err = 0;

  smoldvi_link_seq #(.N_LANES(3), .W_SYM(10), .SETTLE_CYCLES(8), .TRAIN_SYMBOLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked), .sym_in(sym_in),
    .sym_ack(sym_ack), .gb_rst_n_in(gb_rst_n_in), .gb_rst_n_out_req(gb_rst_n_out_req),
    .lane_din(lane_din), .link_up(link_up), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    int b = 0;
    while (cyc < n && b < 500) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (cyc != n) chk("timeout", cyc, n);
  endtask

  task automatic chk_torn(input string tag, input logic [2:0] s);
    chk({tag, "_state"}, state, s);
    chk({tag, "_gbin"}, gb_rst_n_in, 0);
    chk({tag, "_gbout"}, gb_rst_n_out_req, 0);
    chk({tag, "_up"}, link_up, 0);
    chk({tag, "_ack"}, sym_ack, 0);
    chk({tag, "_din"}, lane_din, IDLE);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_torn("rst", 3'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    wait_cyc(1);
    chk("wait_lock", state, 1);
    wait_cyc(10);
    pll_locked = 1'b1;
    wait_cyc(12);
    chk("pre_in", state, 1);
    wait_cyc(13);
    chk("in_state", state, 2);
    chk("in_gbin", gb_rst_n_in, 1);
    chk("in_gbout", gb_rst_n_out_req, 0);
    wait_cyc(20);
    chk("in_end_gbout", gb_rst_n_out_req, 0);
    wait_cyc(21);
    chk("out_state", state, 3);
    chk("out_gbout", gb_rst_n_out_req, 1);
    wait_cyc(28);
    chk("out_end", state, 3);
    wait_cyc(29);
    chk("train_state", state, 4);
    chk("train_din", lane_din, IDLE);
    sym_in = {10'h2aa, 10'h0f0, 10'h155};
    wait_cyc(32);
    chk("train_end_up", link_up, 0);
    chk("train_end_ack", sym_ack, 0);
    chk("train_end_din", lane_din, IDLE);
    wait_cyc(33);
    chk("run_state", state, 5);
    chk("run_up", link_up, 1);
    chk("run_ack", sym_ack, 1);
    sym_in = {10'h001, 10'h3ff, 10'h155};
    wait_cyc(34);
    chk("lane0", lane_din[9:0], 10'h155);
    chk("lane1", lane_din[19:10], 10'h3ff);
    chk("lane2", lane_din[29:20], 10'h001);
    sym_in = {10'h155, 10'h2aa, 10'h0f0};
    wait_cyc(35);
    chk("lanes_b", lane_din, {10'h155, 10'h2aa, 10'h0f0});
    pll_locked = 1'b0;
    wait_cyc(37);
    chk("lockloss_hold", state, 5);
    wait_cyc(38);
    chk_torn("lockloss", 3'd1);
    wait_cyc(40);
    pll_locked = 1'b1;
    wait_cyc(43);
    chk("re_in", state, 2);
    wait_cyc(51);
    chk("re_out", state, 3);
    wait_cyc(59);
    chk("re_train", state, 4);
    wait_cyc(63);
    chk("re_run", link_up, 1);
    wait_cyc(64);
    enable = 1'b0;
    wait_cyc(65);
    chk_torn("en_off", 3'd0);
    enable = 1'b1;
    wait_cyc(66);
    chk("en_restart", state, 1);
    wait_cyc(67);
    chk("en_re_in", state, 2);
    wait_cyc(80);
    chk("so5_state", state, 3);
    enable = 1'b0;
    wait_cyc(81);
    chk_torn("so5_off", 3'd0);
    enable = 1'b1;
    wait_cyc(99);
    chk("t5_train", state, 4);
    pll_locked = 1'b0;
    wait_cyc(101);
    chk("t5_hold", state, 4);
    enable = 1'b0;
    wait_cyc(102);
    chk("t5_prio", state, 0);
    enable = 1'b1;
    pll_locked = 1'b1;
    wait_cyc(105);
    chk("t6_in", state, 2);
    wait_cyc(122);
    chk("t6_train", state, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_torn("async", 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(1);
    chk("post_e1", state, 1);
    wait_cyc(2);
    chk("post_e2", state, 1);
    wait_cyc(3);
    chk("post_e3", state, 2);
    chk("post_gbin", gb_rst_n_in, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
